tas_ram_arbiter: RTL and testbench

TAS_RAM_ARBITER -- requirements
Module: tas_ram_arbiter

---
 rtl/tas_pkg.sv | 15 +
 rtl/tas_ptr_ctr.sv | 21 ++
 rtl/tas_ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_tas_ram_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tas_pkg.sv
// Shared types and constants for the TAS averaged-temperature RAM arbiter.
package tas_pkg;

  localparam int TAS_ADDR_W = 11;
  localparam int TAS_DATA_W = 8;
  localparam logic [TAS_ADDR_W-1:0] TAS_ADDR_TOP = '1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WRITE,
    ARB_RD_ADDR,
    ARB_RD_DATA
  } arb_state_t;

endpackage

// File: rtl/tas_ptr_ctr.sv
// RAM pointer: down-counter that starts at all-ones and wraps from 0 back to all-ones.
module tas_ptr_ctr
  import tas_pkg::*;
#(
  parameter int ADDR_W = TAS_ADDR_W
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr
);

  always_ff @(posedge clk_50) begin
    if (reset) begin
      ptr <= '1;
    end else if (en) begin
      ptr <= ptr - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/tas_ram_arbiter.sv
// Single-port RAM arbiter between the average writer and host readback (oldest-first buffer).
// Optional macro TAS_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; default write wins ties.
module tas_ram_arbiter
  import tas_pkg::*;
#(
  parameter int ADDR_W = TAS_ADDR_W,
  parameter int DATA_W = TAS_DATA_W
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(1) << ADDR_W;

  arb_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              full;
  logic              empty;
  logic              grant_wr;
  logic              wr_ptr_en;
  logic              rd_ptr_en;
  logic              ack_busy;

`ifdef TAS_ARB_ROUND_ROBIN_EN
  logic last_rd;
`endif

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign ack_busy = wr_ack | rd_ack;

  // A write that lands on a full buffer also retires the oldest word.
  assign wr_ptr_en = (state == ARB_WRITE);
  assign rd_ptr_en = ((state == ARB_WRITE) && full) || (state == ARB_RD_DATA);

  always_comb begin
`ifdef TAS_ARB_ROUND_ROBIN_EN
    grant_wr = wr_req && (!rd_req || last_rd);
`else
    grant_wr = wr_req;
`endif
  end

  tas_ptr_ctr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk_50 (clk_50),
    .reset  (reset),
    .en     (wr_ptr_en),
    .ptr    (wr_ptr)
  );

  tas_ptr_ctr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk_50 (clk_50),
    .reset  (reset),
    .en     (rd_ptr_en),
    .ptr    (rd_ptr)
  );

  // Read address is presented on entry to ARB_RD_ADDR so ram_q is ready by ARB_RD_DATA;
  // idle ignores requests while an ack is showing so each ack is followed by an idle cycle.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state    <= ARB_IDLE;
      count    <= '0;
      overflow <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      ram_wr_n <= 1'b1;
      ram_addr <= '1;
      ram_data <= '0;
`ifdef TAS_ARB_ROUND_ROBIN_EN
      last_rd  <= 1'b1;
`endif
    end else begin
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_err   <= 1'b0;
      ram_wr_n <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (!ack_busy) begin
            if (grant_wr) begin
              state <= ARB_WRITE;
`ifdef TAS_ARB_ROUND_ROBIN_EN
              last_rd <= 1'b0;
`endif
            end else if (rd_req) begin
              state <= ARB_RD_ADDR;
              if (!empty) begin
                ram_addr <= rd_ptr;
              end
`ifdef TAS_ARB_ROUND_ROBIN_EN
              last_rd <= 1'b1;
`endif
            end
          end
        end
        ARB_WRITE: begin
          ram_wr_n <= 1'b0;
          ram_addr <= wr_ptr;
          ram_data <= wr_data;
          wr_ack   <= 1'b1;
          if (full) begin
            overflow <= 1'b1;
          end else begin
            count <= count + (ADDR_W+1)'(1);
          end
          state <= ARB_IDLE;
        end
        ARB_RD_ADDR: begin
          if (empty) begin
            rd_ack  <= 1'b1;
            rd_err  <= 1'b1;
            rd_data <= '0;
            state   <= ARB_IDLE;
          end else begin
            state <= ARB_RD_DATA;
          end
        end
        ARB_RD_DATA: begin
          rd_data <= ram_q;
          rd_ack  <= 1'b1;
          count   <= count - (ADDR_W+1)'(1);
          state   <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tas_ram_arbiter.sv
// Randomized bench for tas_ram_arbiter against a queue-based oldest-first buffer model.
module tb_tas_ram_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;

  logic          clk_50 = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          ram_wr_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic [AW:0]   count;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  // Behavioural model: FIFO contents, sticky overflow, total writes issued.
  logic [DW-1:0] model_q[$];
  logic          model_ovf;
  int            n_writes;

  logic [DW-1:0] mem [DEPTH];

  tas_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .ram_wr_n (ram_wr_n),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_q    (ram_q),
    .count    (count),
    .overflow (overflow)
  );

  always #10 clk_50 = ~clk_50;

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk_50) begin
    if (!ram_wr_n) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  function automatic logic [AW-1:0] exp_wr_addr();
    return AW'(DEPTH - 1 - (n_writes % DEPTH));
  endfunction

  function automatic void model_write(input logic [DW-1:0] d);
    if (model_q.size() == DEPTH) begin
      void'(model_q.pop_front());
      model_ovf = 1'b1;
    end
    model_q.push_back(d);
    n_writes++;
  endfunction

  task automatic apply_reset();
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = '0;
    @(posedge clk_50); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk_50);
    #1;
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    n_writes  = 0;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    int lat;
    bit seen;
    logic [AW-1:0] ea;
    ea = exp_wr_addr();
    @(posedge clk_50); #1;
    wr_req  = 1'b1;
    wr_data = d;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk_50);
      lat++;
      @(negedge clk_50);
      if (wr_ack) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wr_timeout: no wr_ack within %0d cycles", lat);
    end else begin
      model_write(d);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL wr_latency: got %0d want 2", lat);
      end
      checks++;
      if (ram_wr_n !== 1'b0 || ram_addr !== ea || ram_data !== d) begin
        errors++;
        $display("FAIL wr_ram: wr_n=%b addr=%h data=%h want wr_n=0 addr=%h data=%h",
                 ram_wr_n, ram_addr, ram_data, ea, d);
      end
      checks++;
      if (count !== (AW+1)'(model_q.size()) || overflow !== model_ovf) begin
        errors++;
        $display("FAIL wr_state: count=%0d ovf=%b want count=%0d ovf=%b",
                 count, overflow, model_q.size(), model_ovf);
      end
    end
    @(posedge clk_50); #1;
    wr_req = 1'b0;
  endtask

  task automatic do_read();
    int lat;
    bit seen;
    bit exp_err;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] addr_before;
    exp_err = (model_q.size() == 0);
    addr_before = ram_addr;
    @(posedge clk_50); #1;
    rd_req = 1'b1;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk_50);
      lat++;
      @(negedge clk_50);
      if (rd_ack) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rd_timeout: no rd_ack within %0d cycles", lat);
    end else begin
      exp_d = exp_err ? '0 : model_q.pop_front();
      checks++;
      if (lat !== (exp_err ? 2 : 3)) begin
        errors++;
        $display("FAIL rd_latency: got %0d want %0d", lat, exp_err ? 2 : 3);
      end
      checks++;
      if (rd_err !== exp_err || rd_data !== exp_d) begin
        errors++;
        $display("FAIL rd_data: data=%h err=%b want data=%h err=%b", rd_data, rd_err, exp_d, exp_err);
      end
      checks++;
      if (count !== (AW+1)'(model_q.size()) || overflow !== model_ovf) begin
        errors++;
        $display("FAIL rd_state: count=%0d ovf=%b want count=%0d ovf=%b",
                 count, overflow, model_q.size(), model_ovf);
      end
      if (exp_err) begin
        checks++;
        if (ram_addr !== addr_before || ram_wr_n !== 1'b1) begin
          errors++;
          $display("FAIL rd_err_ram: addr=%h wr_n=%b want addr=%h wr_n=1", ram_addr, ram_wr_n, addr_before);
        end
      end
    end
    @(posedge clk_50); #1;
    rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (wr_ack !== 1'b0 || rd_ack !== 1'b0 || rd_err !== 1'b0 || rd_data !== '0 ||
        ram_wr_n !== 1'b1 || ram_addr !== '1 || ram_data !== '0 ||
        count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: wr_ack=%b rd_ack=%b rd_err=%b rd_data=%h wr_n=%b addr=%h data=%h count=%0d ovf=%b want 0 0 0 00 1 7ff 00 0 0",
               tag, wr_ack, rd_ack, rd_err, rd_data, ram_wr_n, ram_addr, ram_data, count, overflow);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk_50);
    check_reset_outputs("reset_state");
  endtask

  task automatic test_first_write_read();
    apply_reset();
    do_write(8'h42);
    do_read();
  endtask

  task automatic test_empty_read();
    apply_reset();
    do_read();
    do_write(8'h5a);
    do_read();
    do_read();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) != 0) do_write(DW'($urandom));
      else do_read();
    end
    for (int i = 0; i < 4; i++) do_read();
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++) do_write(DW'(i));
    checks++;
    if (count !== (AW+1)'(DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: count=%0d ovf=%b want count=2048 ovf=1", count, overflow);
    end
    do_read();
    checks++;
    if (rd_data !== 8'h01) begin
      errors++;
      $display("FAIL ovf_oldest: rd_data=%h want 01", rd_data);
    end
  endtask

  task automatic test_tie();
    int grants;
    int cyc;
    bit exp_wr;
    logic [DW-1:0] exp_d;
    apply_reset();
    do_write(8'h10);
    @(posedge clk_50); #1;
    wr_data = DW'($urandom);
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    grants  = 0;
    cyc     = 0;
    while (grants < 6 && cyc < 100) begin
      @(negedge clk_50);
      cyc++;
      if (wr_ack || rd_ack) begin
`ifdef TAS_ARB_ROUND_ROBIN_EN
        exp_wr = (grants % 2) == 0;
`else
        exp_wr = 1'b1;
`endif
        checks++;
        if (wr_ack !== exp_wr || rd_ack !== !exp_wr) begin
          errors++;
          $display("FAIL tie_order: grant %0d wr_ack=%b rd_ack=%b want wr_ack=%b", grants, wr_ack, rd_ack, exp_wr);
        end
        if (wr_ack) begin
          model_write(wr_data);
          wr_data = DW'($urandom);
        end else begin
          exp_d = model_q.pop_front();
          checks++;
          if (rd_data !== exp_d || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL tie_rd_data: data=%h err=%b want %h 0", rd_data, rd_err, exp_d);
          end
        end
        checks++;
        if (count !== (AW+1)'(model_q.size())) begin
          errors++;
          $display("FAIL tie_count: count=%0d want %0d", count, model_q.size());
        end
        grants++;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    checks++;
    if (grants != 6) begin
      errors++;
      $display("FAIL tie_timeout: saw %0d grants want 6", grants);
    end
    repeat (3) @(posedge clk_50);
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    do_write(8'h77);
    @(posedge clk_50); #1;
    rd_req = 1'b1;
    repeat (2) @(posedge clk_50);
    #1;
    reset = 1'b1;
    @(posedge clk_50); #1;
    rd_req = 1'b0;
    @(negedge clk_50);
    check_reset_outputs("reset_mid_read");
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    n_writes  = 0;
    do_read();
  endtask

  initial begin
    reset   = 1'b1;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_data = '0;
    model_ovf = 1'b0;
    n_writes  = 0;
    test_reset();
    test_first_write_read();
    test_empty_read();
    test_random();
    test_tie();
    test_reset_mid_read();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
